// File: rtl/obi_mem_responder_pkg.sv
// Shared types and limits for the OBI memory responder.
package obi_mem_responder_pkg;

    localparam int MAX_RESP_LAT = 8;
    localparam int MAX_GNT_WAIT = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } gnt_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_entry_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response pipeline: valid/data shift register, async cleared.
module obi_resp_pipe
    import obi_mem_responder_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_valid,
    input  resp_entry_t i_entry,
    output logic        o_valid,
    output resp_entry_t o_entry
);

    logic [LAT-1:0] r_valid;
    resp_entry_t    r_stage [LAT];

    // Data is zeroed on empty slots so the output word reads 0 whenever no response is valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_stage[0] <= i_valid ? i_entry : '0;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_entry = r_stage[LAT-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI responder backed by a byte-enabled word memory with configurable grant wait and response latency.
// Optional address range checking: OBI_MEM_RESPONDER_RANGE_ERR_EN.
//
// state   | meaning
// S_IDLE  | no request being counted, wait_cnt = 0 (acts as ready when GNT_WAIT = 0)
// S_WAIT  | request held, wait_cnt counting up towards GNT_WAIT
// S_READY | wait satisfied, grant issued once outstanding cap allows
module obi_mem_responder
    import obi_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS       = 4096,
    parameter int          GNT_WAIT        = 0,
    parameter int          RESP_LAT        = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0200_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         IDX_W      = $clog2(MEM_WORDS);
    localparam logic [3:0] GNT_WAIT_C = 4'(GNT_WAIT);
    localparam logic [3:0] MAX_OUT_C  = 4'(MAX_OUTSTANDING);

    gnt_state_e  r_state;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  r_outstanding;
    logic [31:0] r_mem [MEM_WORDS];

    logic             w_ready;
    logic             w_gnt;
    logic [3:0]       w_cnt_nxt;
    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_word;
    logic             w_in_range;
    logic             w_unused_lo;
    logic             w_rvalid;
    resp_entry_t      w_entry;
    resp_entry_t      w_out;

    assign w_ready   = (r_state == S_READY) || (GNT_WAIT_C == 4'd0);
    assign w_gnt     = req_i & w_ready & ((r_outstanding < MAX_OUT_C) | w_rvalid) & ~rst_i;
    assign gnt_o     = w_gnt;
    assign w_cnt_nxt = r_wait_cnt + 4'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i && (GNT_WAIT_C != 4'd0)) begin
                        r_wait_cnt <= 4'd1;
                        r_state    <= (GNT_WAIT_C == 4'd1) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req_i) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == GNT_WAIT_C) begin
                            r_state <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    // Each grant re-arms the wait, so back-to-back requests pay it again.
                    if (!req_i || w_gnt) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else if (w_gnt && !w_rvalid) begin
            r_outstanding <= r_outstanding + 4'd1;
        end else if (!w_gnt && w_rvalid) begin
            r_outstanding <= r_outstanding - 4'd1;
        end
    end

    assign w_offset    = addr_i - BASE_ADDR;
    assign w_idx       = w_offset[IDX_W+1:2];
    assign w_unused_lo = ^w_offset[1:0];

`ifdef OBI_MEM_RESPONDER_RANGE_ERR_EN
    assign w_in_range = (addr_i >= BASE_ADDR) && ((w_offset >> (IDX_W + 2)) == 32'd0);
`else
    logic w_unused_hi;
    assign w_in_range  = 1'b1;
    assign w_unused_hi = ^w_offset[31:IDX_W+2];
`endif

    assign w_rd_word = r_mem[w_idx];

    // Memory is deliberately not reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_gnt && we_i && w_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        w_entry       = '0;
        w_entry.rdata = (we_i || !w_in_range) ? 32'd0 : w_rd_word;
        w_entry.err   = !w_in_range;
    end

    obi_resp_pipe #(
        .LAT (RESP_LAT)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (w_gnt),
        .i_entry (w_entry),
        .o_valid (w_rvalid),
        .o_entry (w_out)
    );

    assign rvalid_o = w_rvalid;
    assign rdata_o  = w_out.rdata;
    assign err_o    = w_out.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench: default config via vector table, plus wait-state and latency/throttle instances.
module tb_obi_mem_responder;
    import obi_mem_responder_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef OBI_MEM_RESPONDER_RANGE_ERR_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_req = 0, a_we = 0; logic [31:0] a_addr = 0, a_wdata = 0; logic [3:0] a_be = 0;
    logic a_gnt, a_rvalid, a_err; logic [31:0] a_rdata;
    logic g_req = 0, g_we = 0; logic [31:0] g_addr = 0, g_wdata = 0; logic [3:0] g_be = 0;
    logic g_gnt, g_rvalid, g_err; logic [31:0] g_rdata;
    logic l_req = 0, l_we = 0; logic [31:0] l_addr = 0, l_wdata = 0; logic [3:0] l_be = 0;
    logic l_gnt, l_rvalid, l_err; logic [31:0] l_rdata;

    obi_mem_responder u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we),
        .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err));

    obi_mem_responder #(.GNT_WAIT(3)) u_dut_wait (
        .clk_i(clk), .rst_i(rst), .req_i(g_req), .gnt_o(g_gnt), .addr_i(g_addr), .we_i(g_we),
        .be_i(g_be), .wdata_i(g_wdata), .rvalid_o(g_rvalid), .rdata_o(g_rdata), .err_o(g_err));

    obi_mem_responder #(.RESP_LAT(4), .MAX_OUTSTANDING(2)) u_dut_lat (
        .clk_i(clk), .rst_i(rst), .req_i(l_req), .gnt_o(l_gnt), .addr_i(l_addr), .we_i(l_we),
        .be_i(l_be), .wdata_i(l_wdata), .rvalid_o(l_rvalid), .rdata_o(l_rdata), .err_o(l_err));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic g_wait_grant(output int cyc);
        cyc = 1;
        #1;
        while (!g_gnt && cyc < 20) begin
            @(posedge clk); @(negedge clk); #1;
            cyc++;
        end
    endtask

    task automatic l_stream(input logic we, input int n, input string name);
        logic [15:0] gpat, vpat;
        int cyc, issued, retired;
        logic g;
        gpat = '0; vpat = '0; cyc = 0; issued = 0; retired = 0;
        @(negedge clk);
        while ((issued < n || retired < n) && cyc < 40) begin
            l_req = (issued < n); l_we = we; l_be = 4'hF;
            l_addr = BASE + 32'(4 * issued); l_wdata = 32'hA000_0000 + 32'(issued);
            #1;
            if (cyc < 16) begin
                gpat[cyc] = l_gnt;
                vpat[cyc] = l_rvalid;
            end
            if (l_rvalid) begin
                check({name, "_data"}, l_rdata, we ? 32'd0 : 32'hA000_0000 + 32'(retired));
                retired++;
            end
            g = l_gnt;
            @(posedge clk);
            if (g) issued++;
            @(negedge clk);
            cyc++;
        end
        l_req = 0;
        check({name, "_gnt_pattern"}, {16'd0, gpat}, 32'h0000_0333);
        check({name, "_rvalid_pattern"}, {16'd0, vpat}, 32'h0000_3330);
        check({name, "_retired"}, 32'(retired), 32'(n));
    endtask

    task automatic l_single(input logic [31:0] addr, input logic [31:0] exp, input string name);
        int k;
        @(negedge clk);
        l_req = 1; l_we = 0; l_addr = addr; l_be = 4'hF;
        #1 check({name, "_gnt"}, {31'd0, l_gnt}, 32'd1);
        @(posedge clk); @(negedge clk);
        l_req = 0;
        k = 1;
        #1;
        while (!l_rvalid && k < 12) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'd4);
        check({name, "_rdata"}, l_rdata, exp);
    endtask

    initial begin
        int c, nrv;
        vecs[0]  = '{1'b1, 32'h0200_0000, 4'hF, 32'h55AA_55AA, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0200_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0200_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0200_0020, 4'hF, 32'h1122_3344, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 32'h0200_0020, 4'h2, 32'h0000_AB00, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0200_0020, 4'h0, 32'h0,         32'h1122_AB44, 1'b0};
        vecs[6]  = '{1'b1, 32'h0200_0020, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0200_0020, 4'h0, 32'h0,         32'h1122_AB44, 1'b0};
        vecs[8]  = '{1'b1, 32'h0200_3FFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0200_3FFF, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b0, 32'h0200_0013, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h0100_0000, 4'h0, 32'h0,         RANGE_EN ? 32'h0 : 32'h55AA_55AA, RANGE_EN};
        vecs[12] = '{1'b1, 32'h0100_0000, 4'hF, 32'h1234_5678, 32'h0, RANGE_EN};
        vecs[13] = '{1'b0, 32'h0200_0000, 4'h0, 32'h0,         RANGE_EN ? 32'h55AA_55AA : 32'h1234_5678, 1'b0};
        vecs[14] = '{1'b0, 32'h0200_4000, 4'h0, 32'h0,         RANGE_EN ? 32'h0 : 32'h1234_5678, RANGE_EN};
        vecs[15] = '{1'b1, 32'h0200_0010, 4'h9, 32'hAB00_00CD, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 32'h0200_0010, 4'h0, 32'h0,         32'hABAD_BECD, 1'b0};

        // Reset state, with a request pending that must not be granted.
        a_req = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_gnt", {31'd0, a_gnt}, 32'd0);
        check("reset_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("reset_rdata", a_rdata, 32'd0);
        check("reset_err", {31'd0, a_err}, 32'd0);
        check("reset_lat_rvalid", {31'd0, l_rvalid}, 32'd0);
        a_req = 0;
        @(negedge clk) rst = 0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a_req = 1; a_we = vecs[i].we; a_addr = vecs[i].addr;
            a_be = vecs[i].be; a_wdata = vecs[i].wdata;
            #1 check($sformatf("vec%0d_gnt", i), {31'd0, a_gnt}, 32'd1);
            @(posedge clk); @(negedge clk);
            a_req = 0;
            #1;
            check($sformatf("vec%0d_rvalid", i), {31'd0, a_rvalid}, 32'd1);
            check($sformatf("vec%0d_rdata", i), a_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, a_err}, {31'd0, vecs[i].exp_err});
        end
        @(negedge clk); #1;
        check("idle_rvalid", {31'd0, a_rvalid}, 32'd0);

        // Read after write on consecutive grants.
        a_req = 1; a_we = 1; a_addr = BASE + 32'h40; a_be = 4'hF; a_wdata = 32'hA5A5_5A5A;
        @(posedge clk); @(negedge clk);
        a_we = 0;
        #1 check("raw_read_gnt", {31'd0, a_gnt}, 32'd1);
        check("raw_write_rvalid", {31'd0, a_rvalid}, 32'd1);
        @(posedge clk); @(negedge clk);
        a_req = 0;
        #1 check("raw_read_rdata", a_rdata, 32'hA5A5_5A5A);

        // Grant wait states.
        @(negedge clk);
        g_req = 1; g_we = 1; g_addr = BASE; g_be = 4'hF; g_wdata = 32'h0BAD_F00D;
        g_wait_grant(c);
        check("gwait_first_cycle", 32'(c), 32'd4);
        @(posedge clk); @(negedge clk);
        g_we = 0;
        #1 check("gwait_write_rvalid", {31'd0, g_rvalid}, 32'd1);
        g_wait_grant(c);
        check("gwait_b2b_cycle", 32'(c), 32'd4);
        @(posedge clk); @(negedge clk);
        g_req = 0;
        #1 check("gwait_read_rdata", g_rdata, 32'h0BAD_F00D);
        @(negedge clk);
        g_req = 1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        g_req = 0;
        #1 check("gwait_drop_no_gnt", {31'd0, g_gnt}, 32'd0);
        @(negedge clk);
        g_req = 1;
        g_wait_grant(c);
        check("gwait_after_drop_cycle", 32'(c), 32'd4);
        @(posedge clk); @(negedge clk);
        g_req = 0;

        // Latency 4, cap 2: throttled streams.
        l_stream(1'b1, 6, "lat_wr");
        l_stream(1'b0, 6, "lat_rd");

        // Reset with two responses in flight.
        @(negedge clk);
        l_req = 1; l_we = 1; l_addr = BASE + 32'd28; l_be = 4'hF; l_wdata = 32'h7777_7777;
        #1 check("rst_mid_wr_gnt", {31'd0, l_gnt}, 32'd1);
        @(posedge clk); @(negedge clk);
        l_we = 0; l_addr = BASE;
        #1 check("rst_mid_rd_gnt", {31'd0, l_gnt}, 32'd1);
        @(posedge clk); @(negedge clk);
        l_req = 0; rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0;
        nrv = 0;
        for (int i = 0; i < 8; i++) begin
            #1 if (l_rvalid) nrv++;
            @(negedge clk);
        end
        check("rst_mid_no_rvalid", 32'(nrv), 32'd0);
        l_single(BASE + 32'd28, 32'h7777_7777, "rst_mid_word7");
        l_single(BASE, 32'hA000_0000, "rst_mid_word0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
